bidir_bus_ctrl: RTL and testbench
=================================

// Module: bidir_bus_ctrl
// PURPOSE
//   Half-duplex transaction controller for the bidir_io pad stage. It drives the
//   pad's t/i inputs and consumes its o output.
//   - Converts single write/read requests into a timed bus sequence: drive, turnaround,
//     or release-and-sample.
//   - Guarantees io_t is never asserted during a turnaround window.
//   - Synchronises io_o before read capture.
// PARAMETERS
//   WIDTH      8  bus width; must match the bidir_io WIDTH
//   DRIVE_CYC  2  cycles io_t=1 per write (>=1)
//   SAMPLE_DLY 3  cycles released before read capture (>=2, covers 2-flop sync)
//   TURN_CYC   1  idle turnaround cycles after every transaction, io_t=0 (>=1)
// PORTS
//   clk        in   1      clock; everything on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   req_valid  in   1      request present
//   req_ready  out  1      1 only in IDLE; accept = req_valid & req_ready
//   req_wr     in   1      1=write, 0=read; sampled at accept
//   req_wdata  in   WIDTH  write data; sampled at accept
//   rsp_valid  out  1      one-cycle completion pulse (reads and writes)
//   rsp_rdata  out  WIDTH  read data (valid with rsp_valid); 0 for writes
//   busy       out  1      ~req_ready
//   io_t       out  1      to bidir_io.t; 1 = drive pad
//   io_i       out  WIDTH  to bidir_io.i
//   io_o       in   WIDTH  from bidir_io.o (async w.r.t. clk for reads)
//   err_clr    in   1      clears err
//   err        out  1      sticky contention flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset values: state=IDLE, req_ready=1, busy=0, io_t=0, io_i=0,
//     rsp_valid=0, rsp_rdata=0, err=0, counter=0, sync flops=0.
//   - All outputs are registered except req_ready/busy (decoded from state).
//   - FSM: IDLE -> DRIVE (accept, req_wr=1) | SAMPLE (accept, req_wr=0);
//     DRIVE -> TURN after DRIVE_CYC cycles; SAMPLE -> TURN after SAMPLE_DLY cycles;
//     TURN -> IDLE after TURN_CYC cycles.
//   - Write, accept edge at cycle 0:
//     - io_t=1 and io_i=wdata for cycles 1..DRIVE_CYC.
//     - io_t=0 from cycle DRIVE_CYC+1.
//     - io_i returns to 0 in TURN.
//   - Read: io_t stays 0; io_o passes through a 2-flop sync continuously; the sync
//     output is captured at the end of the last SAMPLE cycle.
//   - rsp_valid pulses in the first TURN cycle for both transaction types.
//     - Write latency: accept -> rsp = DRIVE_CYC+1.
//     - Read latency: accept -> rsp = SAMPLE_DLY+1.
//     - Next accept is possible at TURN_CYC cycles after rsp.
//   - req_wdata/req_wr changes after accept have no effect; req_valid outside IDLE
//     is ignored (no queueing).
//   - Down-counter loaded on each state entry with (N-1); it wraps never, transition at 0.
//   - Reset mid-transaction: io_t drops to 0 asynchronously; no rsp_valid is issued
//     for the aborted request.
//   - err_clr and a new error in the same cycle: set wins.
// CONFIGURATION
//   - BIDIR_BUS_CONTENTION_CHK_EN defined: in the last DRIVE cycle, compare io_o to
//     io_i (pad loopback). Any mismatch sets err (sticky until err_clr or reset).
//   - Macro undefined: no compare logic; err is tied 0; err_clr is ignored.
//     The port list is unchanged.
// STRUCTURE
//   - Package bidir_bus_pkg: state enum {IDLE,DRIVE,SAMPLE,TURN}; CNT_W function
//     ($clog2 of max cycle param +1).
//   - Sub-module bidir_sync: WIDTH-wide 2-flop synchroniser with async active-low
//     reset, used on io_o.
//   - Instantiated alongside bidir_io; not wrapping it.
// TESTING (WIDTH=8, DRIVE_CYC=2, SAMPLE_DLY=3, TURN_CYC=1 unless noted)
//   - Write 0xA5 accepted at cycle 0 -> io_t=1, io_i=0xA5 in cycles 1-2; cycle 3
//     io_t=0, rsp_valid=1, rsp_rdata=0x00; req_ready=1 at cycle 4.
//   - Read with external driver holding io_o=0x3C -> io_t=0 throughout; rsp_valid
//     at cycle 4 with rsp_rdata=0x3C.
//   - Write then read, req_valid held high -> second accept at cycle 4; io_t=0 in
//     cycle 3 and for the whole read.
//   - Change req_wdata to 0xFF at cycle 1 of a 0x11 write; pulse req_valid in
//     DRIVE -> io_i stays 0x11; exactly one rsp.
//   - Assert rst_n=0 during cycle 1 of a write -> io_t=0 immediately (no clk edge);
//     no rsp_valid; req_ready=1 after release.
//   - Macro on: write 0xFF while io_o forced 0x00 -> err=1 from cycle 3, held;
//     err_clr -> err=0. Macro off: same stimulus -> err=0.

Source files
------------

// File: rtl/bidir_bus_pkg.sv
// Shared types and helpers for the bidir_io half-duplex transaction controller.
package bidir_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        TURN
    } state_t;

    // Counter width large enough to hold the largest (N-1) cycle load.
    function automatic int cnt_w(input int drive_cyc, input int sample_dly, input int turn_cyc);
        int m;
        m = drive_cyc;
        if (sample_dly > m) m = sample_dly;
        if (turn_cyc > m) m = turn_cyc;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/bidir_sync.sv
// WIDTH-wide two-flop synchroniser for the asynchronous pad readback.
module bidir_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex transaction controller driving the bidir_io pad t/i and sampling o.
// Optional pad-loopback contention check enabled by defining BIDIR_BUS_CONTENTION_CHK_EN.
module bidir_bus_ctrl
    import bidir_bus_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DRIVE_CYC  = 2,
    parameter int SAMPLE_DLY = 3,
    parameter int TURN_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             busy,
    output logic             io_t,
    output logic [WIDTH-1:0] io_i,
    input  logic [WIDTH-1:0] io_o,
    input  logic             err_clr,
    output logic             err
);

    localparam int CW = cnt_w(DRIVE_CYC, SAMPLE_DLY, TURN_CYC);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] io_sync;

    bidir_sync #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (io_o),
        .q     (io_sync)
    );

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;

    // NOTE: every register here uses <= so all branches see pre-edge values of state/cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            io_t      <= 1'b0;
            io_i      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_wr) begin
                            state <= DRIVE;
                            cnt   <= CW'(DRIVE_CYC - 1);
                            io_t  <= 1'b1;
                            io_i  <= req_wdata;
                        end else begin
                            state <= SAMPLE;
                            cnt   <= CW'(SAMPLE_DLY - 1);
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state     <= TURN;
                        cnt       <= CW'(TURN_CYC - 1);
                        io_t      <= 1'b0;
                        io_i      <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SAMPLE: begin
                    // Pad stays released; capture the synchronised value on the last cycle.
                    if (cnt == '0) begin
                        state     <= TURN;
                        cnt       <= CW'(TURN_CYC - 1);
                        rsp_valid <= 1'b1;
                        rsp_rdata <= io_sync;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                TURN: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BIDIR_BUS_CONTENTION_CHK_EN
    logic mismatch;

    // Loopback compare in the last driven cycle; a new mismatch overrides a clear.
    assign mismatch = (state == DRIVE) && (cnt == '0) && (io_o != io_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= mismatch | (err & ~err_clr);
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Scoreboard bench for bidir_bus_ctrl: randomized requests, transaction-level reference model.
module tb_bidir_bus_ctrl;

    localparam int WIDTH      = 8;
    localparam int DRIVE_CYC  = 2;
    localparam int SAMPLE_DLY = 3;
    localparam int TURN_CYC   = 1;

    typedef struct {
        int         rsp_cyc;
        logic [7:0] rdata;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_wr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             busy;
    logic             io_t;
    logic [WIDTH-1:0] io_i;
    logic [WIDTH-1:0] io_o;
    logic             err_clr;
    logic             err;

    // Pad environment: loopback while driven, external driver otherwise, optional forcing.
    logic [7:0] ext;
    logic       force_en;
    logic [7:0] force_val;

    assign io_o = force_en ? force_val : (io_t ? io_i : ext);

    bidir_bus_ctrl #(
        .WIDTH      (WIDTH),
        .DRIVE_CYC  (DRIVE_CYC),
        .SAMPLE_DLY (SAMPLE_DLY),
        .TURN_CYC   (TURN_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .io_t      (io_t),
        .io_i      (io_i),
        .io_o      (io_o),
        .err_clr   (err_clr),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model state
    exp_t       q[$];
    bit         mon_en    = 1'b0;
    bit         cur_wr    = 1'b0;
    int         cur_acc   = -100;
    logic [7:0] cur_data  = '0;
    int         next_free = 0;
    bit         exp_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        cur_wr    = 1'b0;
        cur_acc   = -100;
        next_free = 0;
        exp_err   = 1'b0;
    endtask

    // Monitor: compares every cycle against the model and pops the scoreboard on rsp_valid.
    always @(negedge clk) begin
        if (mon_en) begin
            logic       e_t;
            logic [7:0] e_i;
            logic       e_v;
            exp_t       e;
            e_t = cur_wr && (cyc >= cur_acc + 1) && (cyc <= cur_acc + DRIVE_CYC);
            e_i = e_t ? cur_data : 8'h00;
            check("io_t", io_t, e_t);
            check("io_i", io_i, e_i);
            check("req_ready", req_ready, cyc >= next_free);
            check("busy", busy, cyc < next_free);
            check("err", err, exp_err);
            e_v = (q.size() > 0) && (q[0].rsp_cyc == cyc);
            check("rsp_valid", rsp_valid, e_v);
            if (rsp_valid && q.size() > 0) begin
                e = q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
            end
`ifdef BIDIR_BUS_CONTENTION_CHK_EN
            if (cur_wr && cyc == cur_acc + DRIVE_CYC && force_en && force_val != cur_data)
                exp_err = 1'b1;
            else if (err_clr)
                exp_err = 1'b0;
`endif
        end
    end

    // Issue one request; while waiting for ready, optionally toggle junk requests.
    task automatic run_txn(input logic wr, input logic [7:0] d, input bit noisy, input int gap);
        int   n;
        int   lat;
        exp_t e;
        n = 0;
        while (!req_ready && n < 60) begin
            req_valid = noisy ? 1'($urandom) : 1'b0;
            req_wr    = 1'($urandom);
            req_wdata = 8'($urandom);
            step();
            n++;
        end
        check("ready_wait", req_ready, 1'b1);
        repeat (gap) begin
            req_valid = 1'b0;
            step();
        end
        req_valid = 1'b1;
        req_wr    = wr;
        req_wdata = d;
        if (!wr) ext = d;
        lat       = wr ? DRIVE_CYC + 1 : SAMPLE_DLY + 1;
        e.rsp_cyc = cyc + lat;
        e.rdata   = wr ? 8'h00 : d;
        q.push_back(e);
        cur_wr    = wr;
        cur_acc   = cyc;
        cur_data  = d;
        next_free = cyc + lat + TURN_CYC;
        step();
        req_valid = noisy ? 1'($urandom) : 1'b0;
        req_wr    = 1'($urandom);
        req_wdata = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            req_valid = 1'b0;
            step();
            n++;
        end
        check("drain_empty", q.size(), 0);
        req_valid = 1'b0;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_wdata = '0;
        err_clr   = 1'b0;
        ext       = 8'h00;
        force_en  = 1'b0;
        force_val = 8'h00;
        #1 rst_n = 1'b0;
        repeat (2) step();

        check("rst_req_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_io_t", io_t, 1'b0);
        check("rst_io_i", io_i, 8'h00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;

        // Directed: plain write, plain read, back-to-back with valid held, mid-write data change
        run_txn(1'b1, 8'hA5, 1'b0, 1);
        run_txn(1'b0, 8'h3C, 1'b0, 1);
        drain();
        run_txn(1'b1, 8'h5A, 1'b0, 0);
        req_valid = 1'b1;
        run_txn(1'b0, 8'hC3, 1'b0, 0);
        drain();
        run_txn(1'b1, 8'h11, 1'b1, 0);
        drain();

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        drain();

        // Contention: pad forced low while writing 0xFF, then clear
        force_val = 8'h00;
        force_en  = 1'b1;
        run_txn(1'b1, 8'hFF, 1'b0, 0);
        repeat (6) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        force_en = 1'b0;
        repeat (3) step();

        // Asynchronous reset during the first drive cycle
        run_txn(1'b1, 8'h96, 1'b0, 0);
        check("pre_rst_io_t", io_t, 1'b1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_io_t", io_t, 1'b0);
        check("async_rst_req_ready", req_ready, 1'b1);
        check("async_rst_rsp_valid", rsp_valid, 1'b0);
        clear_model();
        step();
        rst_n = 1'b1;
        clear_model();
        mon_en = 1'b1;
        repeat (6) step();

        for (int i = 0; i < 10; i++) begin
            run_txn(1'($urandom), 8'($urandom), 1'b1, int'($urandom_range(0, 1)));
        end
        drain();
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
